// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI constants for the CPU data-memory AXI master.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_AR,
    ST_RD_R,
    ST_WR,
    ST_WR_B,
    ST_RSP
  } state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/cpu_mem_axi_master.sv
// CPU data-port request/response to single-beat AXI4 reads and writes.
// One transaction in flight at a time; every AXI output comes from a flop.
module cpu_mem_axi_master
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [31:0]           cpu_mem_araddr,
  output logic                  cpu_mem_arvalid,
  output logic [2:0]            cpu_mem_arsize,
  output logic [1:0]            cpu_mem_arburst,
  output logic [7:0]            cpu_mem_arlen,
  input  logic                  cpu_mem_arready,
  input  logic [DATA_WIDTH-1:0] cpu_mem_rdata,
  input  logic                  cpu_mem_rvalid,
  input  logic                  cpu_mem_rlast,
  output logic                  cpu_mem_rready,
  output logic [31:0]           cpu_mem_awaddr,
  output logic                  cpu_mem_awvalid,
  output logic [2:0]            cpu_mem_awsize,
  output logic [1:0]            cpu_mem_awburst,
  output logic [7:0]            cpu_mem_awlen,
  input  logic                  cpu_mem_awready,
  output logic [DATA_WIDTH-1:0] cpu_mem_wdata,
  output logic [3:0]            cpu_mem_wstrb,
  output logic                  cpu_mem_wvalid,
  output logic                  cpu_mem_wlast,
  input  logic                  cpu_mem_wready,
  input  logic                  cpu_mem_bvalid,
  output logic                  cpu_mem_bready
);

  state_e   state_q, state_d;
  mem_req_t req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;

  // arlen is always zero, so the single R beat is always the last one.
  logic unused_rlast;
  assign unused_rlast = cpu_mem_rlast;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    arvalid_d   = 1'b0;
    rready_d    = 1'b0;
    awvalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    bready_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.wen   = req_wen;
          req_d.addr  = 32'(req_addr) & ~32'h3;
          req_d.wdata = req_wdata;
          req_d.wstrb = req_wstrb;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (req_wen) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_RD_AR: begin
        if (cpu_mem_arready) begin
          state_d  = ST_RD_R;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      ST_RD_R: begin
        if (cpu_mem_rvalid) begin
          if (!req_q.wen) rdata_d = cpu_mem_rdata;
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
        end else begin
          rready_d = 1'b1;
        end
      end
      ST_WR: begin
        // AW and W complete independently; leave only once both are done.
        aw_done_d = aw_done_q | (awvalid_q & cpu_mem_awready);
        w_done_d  = w_done_q  | (wvalid_q  & cpu_mem_wready);
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end else begin
          awvalid_d = !aw_done_d;
          wvalid_d  = !w_done_d;
        end
      end
      ST_WR_B: begin
        if (cpu_mem_bvalid) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
        end else begin
          bready_d = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
    end
  end

  // NOTE: the request payload has no reset; it is only observed while a
  // valid flop is high, and those are all reset.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;

  assign cpu_mem_araddr  = req_q.addr;
  assign cpu_mem_arvalid = arvalid_q;
  assign cpu_mem_arsize  = AXI_SIZE_WORD;
  assign cpu_mem_arburst = AXI_BURST_INCR;
  assign cpu_mem_arlen   = AXI_LEN_SINGLE;
  assign cpu_mem_rready  = rready_q;

  assign cpu_mem_awaddr  = req_q.addr;
  assign cpu_mem_awvalid = awvalid_q;
  assign cpu_mem_awsize  = AXI_SIZE_WORD;
  assign cpu_mem_awburst = AXI_BURST_INCR;
  assign cpu_mem_awlen   = AXI_LEN_SINGLE;

  assign cpu_mem_wdata   = req_q.wdata;
  assign cpu_mem_wstrb   = req_q.wstrb;
  assign cpu_mem_wvalid  = wvalid_q;
  assign cpu_mem_wlast   = wvalid_q;
  assign cpu_mem_bready  = bready_q;

endmodule

// File: tb/tb_cpu_mem_axi_master.sv
// Bench for cpu_mem_axi_master: AXI memory slave with programmable delays,
// reference memory model and response scoreboard.
module tb_cpu_mem_axi_master;

  logic        clk, resetn;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [7:0]  arlen, awlen;
  logic [3:0]  wstrb;

  cpu_mem_axi_master dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .cpu_mem_araddr(araddr), .cpu_mem_arvalid(arvalid), .cpu_mem_arsize(arsize),
    .cpu_mem_arburst(arburst), .cpu_mem_arlen(arlen), .cpu_mem_arready(arready),
    .cpu_mem_rdata(rdata), .cpu_mem_rvalid(rvalid), .cpu_mem_rlast(rlast),
    .cpu_mem_rready(rready),
    .cpu_mem_awaddr(awaddr), .cpu_mem_awvalid(awvalid), .cpu_mem_awsize(awsize),
    .cpu_mem_awburst(awburst), .cpu_mem_awlen(awlen), .cpu_mem_awready(awready),
    .cpu_mem_wdata(wdata), .cpu_mem_wstrb(wstrb), .cpu_mem_wvalid(wvalid),
    .cpu_mem_wlast(wlast), .cpu_mem_wready(wready),
    .cpu_mem_bvalid(bvalid), .cpu_mem_bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-transaction slave/CPU timing, set by the stimulus before each request.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, rsp_stall = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          issue_cyc;
  } exp_rsp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } exp_w_t;

  exp_rsp_t    sb[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  exp_w_t      exp_w_q[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI memory slave: samples DUT outputs and drives readies/responses on negedge.
  initial begin
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] rd_addr = 0, aw_a = 0, w_d = 0, p_araddr = 0, p_awaddr = 0, p_wdata = 0;
    logic [3:0]  w_s = 0, p_wstrb = 0;
    bit aw_got = 0, w_got = 0, p_ar = 0, p_aw = 0, p_w = 0;
    arready = 0; rvalid = 0; rdata = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 0; w_got = 0; p_ar = 0; p_aw = 0; p_w = 0;
        continue;
      end
      // B first, so an AW/W handshake decided this cycle cannot mask an early bready.
      if (bready) begin
        check("bready_before_aw_w_done", {aw_got, w_got}, 2'b11);
        if (b_cnt >= b_dly) begin
          bvalid = 1;
          if (aw_got && w_got) slv_mem[aw_a] = merge(slv_rd(aw_a), w_d, w_s);
          aw_got = 0; w_got = 0; b_cnt = 0;
        end else begin
          bvalid = 0; b_cnt++;
        end
      end else begin
        bvalid = 0; b_cnt = 0;
      end
      // AR
      if (p_ar) check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (arvalid) begin
        check("ar_const", {arsize, arburst, arlen}, {3'b010, 2'b01, 8'h00});
        if (ar_cnt >= ar_dly) begin
          arready = 1; ar_cnt = 0; rd_addr = araddr;
          check("ar_pending", exp_ar_q.size(), 1);
          if (exp_ar_q.size() > 0) check("araddr", araddr, exp_ar_q.pop_front());
        end else begin
          arready = 0; ar_cnt++;
        end
      end else begin
        arready = 0; ar_cnt = 0;
      end
      p_ar = arvalid && !arready;
      p_araddr = araddr;
      // R
      if (rready) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1; rdata = slv_rd(rd_addr); rlast = 1; r_cnt = 0;
        end else begin
          rvalid = 0; rdata = $urandom; rlast = 0; r_cnt++;
        end
      end else begin
        rvalid = 0; r_cnt = 0;
      end
      // AW
      if (p_aw) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (awvalid) begin
        check("aw_const", {awsize, awburst, awlen}, {3'b010, 2'b01, 8'h00});
        if (aw_cnt >= aw_dly) begin
          awready = 1; aw_cnt = 0;
          check("aw_duplicate", aw_got, 0);
          aw_got = 1; aw_a = awaddr;
          check("aw_pending", exp_aw_q.size(), 1);
          if (exp_aw_q.size() > 0) check("awaddr", awaddr, exp_aw_q.pop_front());
        end else begin
          awready = 0; aw_cnt++;
        end
      end else begin
        awready = 0; aw_cnt = 0;
      end
      p_aw = awvalid && !awready;
      p_awaddr = awaddr;
      // W
      if (p_w) check("w_stable", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
      if (wvalid) begin
        check("wlast", wlast, 1);
        if (w_cnt >= w_dly) begin
          exp_w_t e;
          wready = 1; w_cnt = 0;
          check("w_duplicate", w_got, 0);
          w_got = 1; w_d = wdata; w_s = wstrb;
          check("w_pending", exp_w_q.size(), 1);
          if (exp_w_q.size() > 0) begin
            e = exp_w_q.pop_front();
            check("wdata_wstrb", {wdata, wstrb}, {e.d, e.s});
          end
        end else begin
          wready = 0; w_cnt++;
        end
      end else begin
        wready = 0; w_cnt = 0;
      end
      p_w = wvalid && !wready;
      p_wdata = wdata;
      p_wstrb = wstrb;
    end
  end

  // Response monitor: pops the scoreboard on each rsp handshake.
  initial begin
    int stall = 0;
    bit active = 0, chk_rr = 0;
    logic [31:0] first_rd = 0;
    exp_rsp_t e;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rsp_ready = 0; active = 0; stall = 0; chk_rr = 0;
        continue;
      end
      if (chk_rr) begin
        check("req_ready_after_rsp", req_ready, 1);
        chk_rr = 0;
      end
      if (rsp_valid) begin
        check("quiet_during_rsp", {req_ready, arvalid, awvalid, wvalid, rready, bready}, 0);
        if (!active) begin
          active = 1; first_rd = rsp_rdata; stall = 0;
          check("rsp_expected", sb.size(), 1);
          if (sb.size() > 0) check("rsp_latency", cyc - sb[0].issue_cyc, sb[0].lat);
        end else begin
          check("rsp_rdata_stable", rsp_rdata, first_rd);
        end
        if (stall >= rsp_stall) begin
          rsp_ready = 1;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
          end
          active = 0; chk_rr = 1;
        end else begin
          rsp_ready = 0; stall++;
        end
      end else begin
        if (active) check("rsp_valid_held", rsp_valid, 1);
        active = 0;
        rsp_ready = 0;
      end
    end
  end

  task automatic issue(input bit wen, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    exp_rsp_t    e;
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
    for (int k = 0; k < 200 && !req_ready; k++) @(negedge clk);
    check("req_accept", req_ready, 1);
    if (wen) begin
      ref_mem[wa] = merge(ref_rd(wa), d, s);
      e.rdata = last_load;
      e.lat   = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      exp_aw_q.push_back(wa);
      exp_w_q.push_back('{d, s});
    end else begin
      e.rdata   = ref_rd(wa);
      last_load = e.rdata;
      e.lat     = 3 + ar_dly + r_dly;
      exp_ar_q.push_back(wa);
    end
    e.issue_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 0; req_wen = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = $urandom;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    check("txn_complete_in_time", sb.size(), 0);
    sb.delete();
  endtask

  task automatic txn(input bit wen, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int ar, input int r, input int aw,
                     input int w, input int b, input int st);
    ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; rsp_stall = st;
    issue(wen, a, d, s);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    ref_mem[32'h1004] = 32'hDEAD_BEEF;
    slv_mem[32'h1004] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("reset_valids_readies",
          {req_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready}, 7'b1000000);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    resetn = 1;

    // Load, arready one cycle late and rvalid one cycle late: rsp at cycle 5.
    txn(0, 32'h0000_1004, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0);
    // Store with unaligned address; W accepted three cycles before AW.
    txn(1, 32'h0000_2002, 32'hCAFE_F00D, 4'b0011, 0, 0, 3, 0, 0, 0);
    txn(0, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    // Store with simultaneous AW/W, B delayed by five cycles.
    txn(1, 32'h0000_2008, 32'h1234_5678, 4'b1111, 0, 0, 0, 0, 5, 0);
    // Load followed by a ten-cycle CPU stall.
    txn(0, 32'h0000_2008, 32'h0, 4'h0, 2, 0, 0, 0, 0, 10);

    // Reset while waiting for R.
    ar_dly = 0; r_dly = 8; rsp_stall = 0;
    issue(0, 32'h0000_1004, 32'h0, 4'h0);
    for (int k = 0; k < 20 && !rready; k++) @(negedge clk);
    check("reached_rd_r", rready, 1);
    resetn = 0;
    sb.delete(); exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    last_load = 32'h0;
    @(negedge clk);
    check("midreset_valids_readies",
          {req_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready}, 7'b1000000);
    check("midreset_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    resetn = 1;
    txn(1, 32'h0000_2010, 32'hA5A5_5A5A, 4'b1001, 0, 0, 1, 2, 1, 0);
    txn(0, 32'h0000_1004, 32'h0, 4'h0, 1, 3, 0, 0, 0, 1);

    // Randomized traffic over a small window so loads observe earlier stores.
    for (int i = 0; i < 80; i++) begin
      txn($urandom_range(0, 1), 32'h0000_3000 + 32'($urandom_range(0, 63)),
          $urandom, 4'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
          $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
